// File: rtl/core_pkg.sv
// Shared definitions for the 65c02 ALU / PSR flag path: operation codes,
// ALU sequencer states, PSR bit positions and the default ack timeout.
// ALU_BCD_EN adds the decimal-adjust state to the sequencer.
package core_pkg;

    typedef enum logic [3:0] {
        OpAdc = 4'd0,
        OpSbc = 4'd1,
        OpAnd = 4'd2,
        OpOra = 4'd3,
        OpEor = 4'd4,
        OpAsl = 4'd5,
        OpLsr = 4'd6,
        OpRol = 4'd7,
        OpRor = 4'd8,
        OpInc = 4'd9,
        OpDec = 4'd10,
        OpCmp = 4'd11,
        OpBit = 4'd12,
        OpTrb = 4'd13,
        OpTsb = 4'd14
    } alu_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
`ifdef ALU_BCD_EN
        StBcdAdj,
`endif
        StReq,
        StDone
    } alu_state_t;

    // PSR byte layout {N,V,X,B,D,I,Z,C}
    localparam int unsigned PSR_N = 7;
    localparam int unsigned PSR_V = 6;
    localparam int unsigned PSR_X = 5;
    localparam int unsigned PSR_B = 4;
    localparam int unsigned PSR_D = 3;
    localparam int unsigned PSR_I = 2;
    localparam int unsigned PSR_Z = 1;
    localparam int unsigned PSR_C = 0;

    localparam int unsigned ACK_TIMEOUT_DEF = 15;

endpackage

// File: rtl/alu_flag_unit_if.sv
// Flag-update link between the ALU and the processor status register:
// four-phase request/ack plus the N/V/Z/C flag values.
// Identical in all builds (ALU_BCD_EN has no effect here).
interface alu_flag_unit_if;

    logic psr_update_request;
    logic ack_update_request;
    logic n_result;
    logic v_result;
    logic z_result;
    logic c_result;

    // ALU side drives request and flags
    modport master (
        output psr_update_request,
        output n_result,
        output v_result,
        output z_result,
        output c_result,
        input  ack_update_request
    );

    // PSR side consumes flags and acknowledges
    modport slave (
        input  psr_update_request,
        input  n_result,
        input  v_result,
        input  z_result,
        input  c_result,
        output ack_update_request
    );

endinterface

// File: rtl/bcd_adjust.sv
// Combinational BCD correction of a binary ADC/SBC sum.
// Only built when ALU_BCD_EN is defined; binary-only builds have no decimal path.
`ifdef ALU_BCD_EN
module bcd_adjust (
    input  logic [7:0] bin_sum,
    input  logic       half_carry,
    input  logic       carry,
    input  logic       is_sub,
    output logic [7:0] dec_sum,
    output logic       dec_carry
);

    logic       lo_fix;
    logic       hi_fix;
    logic [7:0] adj;

    // Pick the 0x06 / 0x60 corrections and apply them in the op's direction
    always_comb begin
        if (is_sub) begin
            // Carry clear means a borrow happened out of that digit
            lo_fix    = ~half_carry;
            hi_fix    = ~carry;
            dec_carry = carry;
        end else begin
            // Comparing the whole byte against 0x99 also catches a high digit of 9
            // that overflows once the low-digit correction carries into it
            lo_fix    = (bin_sum[3:0] > 4'd9) || half_carry;
            hi_fix    = (bin_sum > 8'h99) || carry;
            dec_carry = hi_fix;
        end
        adj     = {1'b0, hi_fix, hi_fix, 1'b0, 1'b0, lo_fix, lo_fix, 1'b0};
        dec_sum = is_sub ? (bin_sum - adj) : (bin_sum + adj);
    end

endmodule
`endif

// File: rtl/alu_flag_unit.sv
// Sequenced 8-bit ALU for the 65c02 core. Latches operands on op_start,
// computes result and N/V/Z/C, then hands the flags to the PSR over a
// four-phase request/ack handshake with an abort timeout.
// Define ALU_BCD_EN to enable decimal-mode ADC/SBC (extra BCD_ADJ cycle);
// without it d_decimal is ignored and ADC/SBC are always binary.
module alu_flag_unit
    import core_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int unsigned ACK_CNT_W   = 8
) (
    input  logic            fclk,
    input  logic            rst,
    input  logic            op_start,
    input  alu_op_t         alu_op,
    input  logic [7:0]      a_in,
    input  logic [7:0]      b_in,
    input  logic [7:0]      psr_in,
    input  logic            c_carry,
    input  logic            d_decimal,
    alu_flag_unit_if.master psr_bus,
    output logic [7:0]      result,
    output logic            result_valid,
    output logic            busy,
    output logic            ack_timeout
);

    localparam logic [ACK_CNT_W-1:0] ACK_LIMIT = ACK_CNT_W'(ACK_TIMEOUT);

    // Sequencer state
    alu_state_t           state_q, state_d;
    logic [ACK_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 req_q, req_d;
    logic                 valid_q, valid_d;
    logic                 tmo_q, tmo_d;
    logic                 busy_q;
    logic                 load_en;
    logic                 calc_en;
    logic                 ack;

    // Operands captured at op_start
    alu_op_t    op_q;
    logic [7:0] a_q, b_q;
    logic       c_in_q;
    logic       pn_q, pv_q, pz_q, pc_q;

    // Result and flag registers driven to the PSR
    logic [7:0] result_q;
    logic       n_q, v_q, z_q, c_q;

    // Binary compute
    logic [7:0] b_eff;
    logic       carry_in;
    logic [8:0] sum9;
    logic [7:0] calc_res;
    logic       calc_n, calc_v, calc_z, calc_c;
    logic       nz_from_res;

`ifdef ALU_BCD_EN
    logic       dec_q;
    logic       hc_q;
    logic [4:0] lo5;
    logic       bcd_en;
    logic [7:0] bcd_res;
    logic       bcd_c;
    logic       unused_in;

    assign unused_in = ^{psr_in[PSR_X], psr_in[PSR_B], psr_in[PSR_D], psr_in[PSR_I]};
`else
    logic       unused_in;

    assign unused_in = ^{psr_in[PSR_X], psr_in[PSR_B], psr_in[PSR_D], psr_in[PSR_I],
                         d_decimal};
`endif

    assign ack = psr_bus.ack_update_request;

    // 9-bit add with SBC/CMP folded in as A + ~B + C; per-op result and flags
    always_comb begin
        b_eff       = (op_q == OpSbc || op_q == OpCmp) ? ~b_q : b_q;
        carry_in    = (op_q == OpCmp) ? 1'b1 : c_in_q;
        sum9        = {1'b0, a_q} + {1'b0, b_eff} + {8'h00, carry_in};
        calc_res    = a_q;
        calc_n      = pn_q;
        calc_v      = pv_q;
        calc_z      = pz_q;
        calc_c      = pc_q;
        nz_from_res = 1'b0;
        case (op_q)
            OpAdc, OpSbc: begin
                calc_res    = sum9[7:0];
                calc_v      = (a_q[7] == b_eff[7]) && (sum9[7] != a_q[7]);
                calc_c      = sum9[8];
                nz_from_res = 1'b1;
            end
            OpAnd: begin
                calc_res    = a_q & b_q;
                nz_from_res = 1'b1;
            end
            OpOra: begin
                calc_res    = a_q | b_q;
                nz_from_res = 1'b1;
            end
            OpEor: begin
                calc_res    = a_q ^ b_q;
                nz_from_res = 1'b1;
            end
            OpAsl: begin
                calc_res    = {a_q[6:0], 1'b0};
                calc_c      = a_q[7];
                nz_from_res = 1'b1;
            end
            OpLsr: begin
                calc_res    = {1'b0, a_q[7:1]};
                calc_c      = a_q[0];
                nz_from_res = 1'b1;
            end
            OpRol: begin
                calc_res    = {a_q[6:0], c_in_q};
                calc_c      = a_q[7];
                nz_from_res = 1'b1;
            end
            OpRor: begin
                calc_res    = {c_in_q, a_q[7:1]};
                calc_c      = a_q[0];
                nz_from_res = 1'b1;
            end
            OpInc: begin
                calc_res    = a_q + 8'd1;
                nz_from_res = 1'b1;
            end
            OpDec: begin
                calc_res    = a_q - 8'd1;
                nz_from_res = 1'b1;
            end
            // Compare leaves the register value untouched; result echoes A
            OpCmp: begin
                calc_n = sum9[7];
                calc_z = (a_q == b_q);
                calc_c = sum9[8];
            end
            OpBit: begin
                calc_n = b_q[7];
                calc_v = b_q[6];
                calc_z = (a_q & b_q) == 8'h00;
            end
            OpTrb: begin
                calc_res = b_q & ~a_q;
                calc_z   = (a_q & b_q) == 8'h00;
            end
            OpTsb: begin
                calc_res = b_q | a_q;
                calc_z   = (a_q & b_q) == 8'h00;
            end
            default: ;
        endcase
        if (nz_from_res) begin
            calc_n = calc_res[7];
            calc_z = (calc_res == 8'h00);
        end
    end

`ifdef ALU_BCD_EN
    // Low-nibble carry for the decimal correction
    always_comb begin
        lo5 = {1'b0, a_q[3:0]} + {1'b0, b_eff[3:0]} + {4'h0, carry_in};
    end

    bcd_adjust u_bcd_adjust (
        .bin_sum    (result_q),
        .half_carry (hc_q),
        .carry      (c_q),
        .is_sub     (op_q == OpSbc),
        .dec_sum    (bcd_res),
        .dec_carry  (bcd_c)
    );
`endif

    // Next-state logic: compute, optional decimal adjust, then the ack handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + ACK_CNT_W'(1);
        req_d   = 1'b0;
        valid_d = 1'b0;
        tmo_d   = 1'b0;
        load_en = 1'b0;
        calc_en = 1'b0;
`ifdef ALU_BCD_EN
        bcd_en  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (op_start) begin
                    load_en = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                calc_en = 1'b1;
                state_d = StReq;
                req_d   = 1'b1;
`ifdef ALU_BCD_EN
                if (dec_q && (op_q == OpAdc || op_q == OpSbc)) begin
                    state_d = StBcdAdj;
                    req_d   = 1'b0;
                end
`endif
            end
`ifdef ALU_BCD_EN
            StBcdAdj: begin
                bcd_en  = 1'b1;
                state_d = StReq;
                req_d   = 1'b1;
            end
`endif
            StReq: begin
                if (ack) begin
                    state_d = StDone;
                end else if (cnt_inc == ACK_LIMIT) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                end else begin
                    req_d = 1'b1;
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                if (!ack) begin
                    state_d = StIdle;
                    valid_d = 1'b1;
                end else if (cnt_inc == ACK_LIMIT) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
        // Every state starts its wait budget from zero
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Sequencer registers and registered handshake/status outputs
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    // Operand capture and result/flag update
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            op_q     <= OpAdc;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            c_in_q   <= 1'b0;
            pn_q     <= 1'b0;
            pv_q     <= 1'b0;
            pz_q     <= 1'b0;
            pc_q     <= 1'b0;
            result_q <= 8'h00;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
`ifdef ALU_BCD_EN
            dec_q    <= 1'b0;
            hc_q     <= 1'b0;
`endif
        end else begin
            if (load_en) begin
                op_q   <= alu_op;
                a_q    <= a_in;
                b_q    <= b_in;
                c_in_q <= c_carry;
                pn_q   <= psr_in[PSR_N];
                pv_q   <= psr_in[PSR_V];
                pz_q   <= psr_in[PSR_Z];
                pc_q   <= psr_in[PSR_C];
`ifdef ALU_BCD_EN
                dec_q  <= d_decimal;
`endif
            end
            if (calc_en) begin
                result_q <= calc_res;
                n_q      <= calc_n;
                v_q      <= calc_v;
                z_q      <= calc_z;
                c_q      <= calc_c;
`ifdef ALU_BCD_EN
                hc_q     <= lo5[4];
`endif
            end
`ifdef ALU_BCD_EN
            // V keeps its binary value; N and Z follow the corrected byte
            if (bcd_en) begin
                result_q <= bcd_res;
                n_q      <= bcd_res[7];
                z_q      <= (bcd_res == 8'h00);
                c_q      <= bcd_c;
            end
`endif
        end
    end

    assign psr_bus.psr_update_request = req_q;
    assign psr_bus.n_result           = n_q;
    assign psr_bus.v_result           = v_q;
    assign psr_bus.z_result           = z_q;
    assign psr_bus.c_result           = c_q;
    assign result                     = result_q;
    assign result_valid               = valid_q;
    assign busy                       = busy_q;
    assign ack_timeout                = tmo_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: scoreboard of expected
// {result,N,V,Z,C} popped on result_valid, plus latency, timeout and
// asynchronous-reset checks. Decimal expectations follow ALU_BCD_EN.
module tb_alu_flag_unit;
    import core_pkg::*;

    localparam int unsigned TMO = 15;
`ifdef ALU_BCD_EN
    localparam int DEC_LAT = 3;
`else
    localparam int DEC_LAT = 2;
`endif

    logic       fclk;
    logic       rst;
    logic       op_start;
    alu_op_t    alu_op;
    logic [7:0] a_in, b_in, psr_in;
    logic       c_carry, d_decimal;
    logic [7:0] result;
    logic       result_valid, busy, ack_timeout;

    logic       ack_en, ack_force;
    int         total, bad, rv_count;
    logic [11:0] sb_q[$];

    alu_flag_unit_if psr_bus ();

    alu_flag_unit #(
        .ACK_TIMEOUT (TMO),
        .ACK_CNT_W   (8)
    ) dut (
        .fclk         (fclk),
        .rst          (rst),
        .op_start     (op_start),
        .alu_op       (alu_op),
        .a_in         (a_in),
        .b_in         (b_in),
        .psr_in       (psr_in),
        .c_carry      (c_carry),
        .d_decimal    (d_decimal),
        .psr_bus      (psr_bus),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .ack_timeout  (ack_timeout)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    // PSR model: ack follows request one cycle later; ack_force holds it high
    initial begin
        psr_bus.ack_update_request = 1'b0;
        forever begin
            @(posedge fclk);
            #1;
            psr_bus.ack_update_request = ack_force | (ack_en & psr_bus.psr_update_request);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model for binary operation, written with integer arithmetic
    function automatic logic [11:0] ref_model(alu_op_t op, logic [7:0] a, logic [7:0] b,
                                              logic [7:0] p, logic ci);
        int ia, ib, sa, sb, r, s, cin;
        logic [7:0] res;
        logic n, v, z, c, nz;
        ia  = int'(a);
        ib  = int'(b);
        cin = ci ? 1 : 0;
        sa  = (ia > 127) ? ia - 256 : ia;
        sb  = (ib > 127) ? ib - 256 : ib;
        res = a;
        n = p[7]; v = p[6]; z = p[1]; c = p[0];
        nz = 1'b1;
        case (op)
            OpAdc: begin
                r = ia + ib + cin; s = sa + sb + cin;
                res = 8'(r); c = (r > 255); v = (s > 127) || (s < -128);
            end
            OpSbc: begin
                r = ia - ib - (1 - cin); s = sa - sb - (1 - cin);
                res = 8'(r); c = (r >= 0); v = (s > 127) || (s < -128);
            end
            OpAnd: res = a & b;
            OpOra: res = a | b;
            OpEor: res = a ^ b;
            OpAsl: begin res = 8'(ia * 2); c = (ia >= 128); end
            OpLsr: begin res = 8'(ia / 2); c = (ia % 2 == 1); end
            OpRol: begin res = 8'(ia * 2 + cin); c = (ia >= 128); end
            OpRor: begin res = 8'(ia / 2 + 128 * cin); c = (ia % 2 == 1); end
            OpInc: res = 8'(ia + 1);
            OpDec: res = 8'(ia - 1);
            OpCmp: begin
                nz = 1'b0; c = (ia >= ib); z = (ia == ib); n = (((ia - ib) & 128) != 0);
            end
            OpBit: begin nz = 1'b0; n = b[7]; v = b[6]; z = ((a & b) == 0); end
            OpTrb: begin nz = 1'b0; res = b & ~a; z = ((a & b) == 0); end
            OpTsb: begin nz = 1'b0; res = b | a; z = ((a & b) == 0); end
            default: nz = 1'b0;
        endcase
        if (nz) begin
            n = res[7];
            z = (res == 8'h00);
        end
        return {res, n, v, z, c};
    endfunction

    // Compare DUT output against the scoreboard on every result_valid pulse
    always @(negedge fclk) begin
        if (result_valid) begin
            rv_count++;
            if (sb_q.size() == 0) begin
                check_value("sb_unexpected", sb_q.size(), 1);
            end else begin
                check_value("sb_result", {result, psr_bus.n_result, psr_bus.v_result,
                            psr_bus.z_result, psr_bus.c_result}, sb_q.pop_front());
            end
        end
    end

    task automatic drive_op(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] p, input logic ci, input logic di);
        @(negedge fclk);
        alu_op    = op;
        a_in      = a;
        b_in      = b;
        psr_in    = p;
        c_carry   = ci;
        d_decimal = di;
        op_start  = 1'b1;
        @(negedge fclk);
        op_start  = 1'b0;
    endtask

    // Wait (bounded) for the request; returns cycles since the op_start cycle
    task automatic wait_req(output int lat);
        lat = 1;
        while (!psr_bus.psr_update_request && lat < 20) begin
            @(negedge fclk);
            lat++;
        end
    endtask

    task automatic run_op(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] p, input logic ci, input logic di,
                          input logic [11:0] want, input int want_lat);
        int lat;
        int rv0;
        rv0 = rv_count;
        sb_q.push_back(want);
        drive_op(op, a, b, p, ci, di);
        check_value("busy_during_op", busy, 1);
        wait_req(lat);
        check_value("req_latency", lat, want_lat);
        for (int k = 0; k < 40 && rv_count == rv0; k++) begin
            @(negedge fclk);
            #1;
        end
        check_value("valid_seen", rv_count - rv0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        alu_op_t    op_v;
        logic [7:0] ra, rb, rp;
        logic       rc;
        int         lat, hi, rv0;

        total = 0; bad = 0; rv_count = 0;
        ack_en = 1'b1; ack_force = 1'b0;
        op_start = 1'b0; alu_op = OpAdc;
        a_in = 8'h00; b_in = 8'h00; psr_in = 8'h00;
        c_carry = 1'b0; d_decimal = 1'b0;
        rst = 1'b1;

        // Reset state
        repeat (2) @(negedge fclk);
        check_value("rst_result", result, 8'h00);
        check_value("rst_req", psr_bus.psr_update_request, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_valid", result_valid, 0);
        check_value("rst_tmo", ack_timeout, 0);
        check_value("rst_flags", {psr_bus.n_result, psr_bus.v_result, psr_bus.z_result,
                    psr_bus.c_result}, 4'b0000);
        rst = 1'b0;
        @(negedge fclk);

        // Directed vectors
        run_op(OpAdc, 8'h50, 8'h50, 8'h00, 1'b0, 1'b0, {8'hA0, 4'b1100}, 2);
`ifdef ALU_BCD_EN
        run_op(OpAdc, 8'h58, 8'h46, 8'h08, 1'b1, 1'b1, {8'h05, 4'b0101}, DEC_LAT);
        run_op(OpSbc, 8'h12, 8'h21, 8'h08, 1'b1, 1'b1, {8'h91, 4'b1000}, DEC_LAT);
        run_op(OpAdc, 8'h99, 8'h01, 8'h08, 1'b0, 1'b1, {8'h00, 4'b0011}, DEC_LAT);
`else
        run_op(OpAdc, 8'h58, 8'h46, 8'h08, 1'b1, 1'b1, {8'h9F, 4'b1100}, DEC_LAT);
        run_op(OpSbc, 8'h12, 8'h21, 8'h08, 1'b1, 1'b1, {8'hF1, 4'b1000}, DEC_LAT);
        run_op(OpAdc, 8'h99, 8'h01, 8'h08, 1'b0, 1'b1, {8'h9A, 4'b1000}, DEC_LAT);
`endif
        run_op(OpCmp, 8'h40, 8'h40, 8'h40, 1'b0, 1'b0, {8'h40, 4'b0111}, 2);
        run_op(OpInc, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, {8'h00, 4'b0010}, 2);
        run_op(OpAsl, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, {8'h00, 4'b0011}, 2);

        // Every opcode once against the reference model
        for (int i = 0; i < 15; i++) begin
            op_v = alu_op_t'(i);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = 8'($urandom);
            rc = 1'($urandom);
            run_op(op_v, ra, rb, rp, rc, 1'b0, ref_model(op_v, ra, rb, rp, rc), 2);
        end

        // Ack held high while idle must not start anything
        ack_force = 1'b1;
        repeat (3) @(negedge fclk);
        check_value("idle_ack_busy", busy, 0);
        check_value("idle_ack_req", psr_bus.psr_update_request, 0);
        ack_force = 1'b0;
        repeat (2) @(negedge fclk);

        // Ack never comes: abort after TMO cycles; a stray op_start is ignored
        ack_en = 1'b0;
        rv0 = rv_count;
        drive_op(OpAdc, 8'h50, 8'h50, 8'h00, 1'b0, 1'b0);
        a_in = 8'h01;
        b_in = 8'h01;
        wait_req(lat);
        hi = 0;
        while (psr_bus.psr_update_request && hi < 300) begin
            hi++;
            op_start = (hi == 3);
            @(negedge fclk);
        end
        op_start = 1'b0;
        check_value("tmo_req_cycles", hi, TMO);
        check_value("tmo_pulse", ack_timeout, 1);
        check_value("tmo_busy", busy, 0);
        check_value("tmo_result_kept", result, 8'hA0);
        @(negedge fclk);
        check_value("tmo_pulse_len", ack_timeout, 0);
        check_value("tmo_stray_ignored", busy, 0);
        check_value("tmo_no_valid", rv_count - rv0, 0);
        ack_en = 1'b1;
        run_op(OpEor, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b0, {8'h0F, 4'b0000}, 2);

        // Reset while requesting clears everything without a clock edge
        ack_en = 1'b0;
        rv0 = rv_count;
        drive_op(OpAdc, 8'h50, 8'h50, 8'h00, 1'b0, 1'b0);
        wait_req(lat);
        check_value("pre_rst_req", psr_bus.psr_update_request, 1);
        #2 rst = 1'b1;
        #1;
        check_value("async_rst_req", psr_bus.psr_update_request, 0);
        check_value("async_rst_busy", busy, 0);
        check_value("async_rst_result", result, 8'h00);
        check_value("async_rst_flags", {psr_bus.n_result, psr_bus.v_result,
                    psr_bus.z_result, psr_bus.c_result}, 4'b0000);
        @(negedge fclk);
        rst = 1'b0;
        ack_en = 1'b1;
        @(negedge fclk);
        check_value("rst_no_valid", rv_count - rv0, 0);
        run_op(OpOra, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, {8'h81, 4'b1000}, 2);

        repeat (3) @(negedge fclk);
        check_value("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
